spi_master_seq: RTL and testbench

SPI master sequencer that drives the SPI-RAM wrapper's serial port. It accepts one 10-bit command word at a time from a host-side valid/ready interface and generates SS_n/MOSI framing in the slave's command format. For read-data commands it captures the 8-bit MISO reply and returns it on a response port. It enforces the read-address → read-data ordering the slave requires.

---
 rtl/spi_master_seq.sv | 148 ++++++++++++++
 tb/tb_spi_master_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_seq.sv
// rtl/spi_master_seq.sv - SPI master sequencer for the SPI-RAM command port.
// Serializes {op, payload} frames, captures read-data replies, rejects unpaired reads.
module spi_master_seq #(
  parameter int RD_WAIT = 3,
  parameter int GAP     = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [7:0] i_cmd_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_err,
  output logic       o_busy,
  output logic       o_ss_n,
  output logic       o_mosi,
  input  logic       i_miso
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_END     = 3'd5;

  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam logic [3:0] L_WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] L_GAP_LAST  = 4'(GAP - 1);

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [9:0] r_frame;
  logic [6:0] r_shift;
  logic       r_rd_pending;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_err;

  logic w_accept;
  logic w_reject;
  logic w_ss_n;
  logic w_mosi;

  assign w_accept = i_cmd_valid && (r_state == S_IDLE);
  assign w_reject = w_accept && (i_cmd_op == OP_RD_DATA) && !r_rd_pending;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_frame      <= 10'd0;
      r_shift      <= 7'd0;
      r_rd_pending <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 8'h00;
      r_err        <= 1'b0;
    end else begin
      r_err       <= w_reject;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_reject) begin
            // Read-data frames carry zero dummy bits regardless of the payload.
            r_frame <= {i_cmd_op, (i_cmd_op == OP_RD_DATA) ? 8'h00 : i_cmd_data};
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= 4'd9;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_cnt == 4'd0) begin
            if (r_frame[9:8] == OP_RD_DATA) begin
              r_cnt   <= L_WAIT_LAST;
              r_state <= S_WAIT;
            end else begin
              if (r_frame[9:8] == OP_RD_ADDR) r_rd_pending <= 1'b1;
              r_cnt   <= L_GAP_LAST;
              r_state <= S_END;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_cnt   <= 4'd7;
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          r_shift <= {r_shift[5:0], i_miso};
          if (r_cnt == 4'd0) begin
            r_rsp_data   <= {r_shift, i_miso};
            r_rsp_valid  <= 1'b1;
            r_rd_pending <= 1'b0;
            r_cnt        <= L_GAP_LAST;
            r_state      <= S_END;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_END: begin
          if (r_cnt == 4'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ss_n = 1'b1;
    w_mosi = 1'b0;
    case (r_state)
      S_START: begin
        w_ss_n = 1'b0;
        w_mosi = r_frame[9];
      end
      S_SHIFT: begin
        w_ss_n = 1'b0;
        w_mosi = r_frame[r_cnt];
      end
      S_WAIT, S_CAPTURE: w_ss_n = 1'b0;
      default: begin
        w_ss_n = 1'b1;
        w_mosi = 1'b0;
      end
    endcase
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_ss_n      = w_ss_n;
  assign o_mosi      = w_mosi;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_err       = r_err;

endmodule

// File: tb/tb_spi_master_seq.sv
// tb/tb_spi_master_seq.sv - directed table-driven bench for spi_master_seq.
// Traces are sampled on the falling edge; index 0 is the handshake cycle.
module tb_spi_master_seq;

  localparam int RDW  = 3;
  localparam int GAPC = 1;
  localparam int NCYC = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       miso = 1'b0;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       err;
  logic       busy;
  logic       ss_n;
  logic       mosi;

  spi_master_seq #(.RD_WAIT(RDW), .GAP(GAPC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_err       (err),
    .o_busy      (busy),
    .o_ss_n      (ss_n),
    .o_mosi      (mosi),
    .i_miso      (miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  d;
    logic [7:0]  mb;
    logic [10:0] mosi;
    int          ss_low;
    bit          err;
    bit          rsp;
  } vec_t;

  vec_t tbl[9];

  logic       ss_tr[0:63];
  logic       mosi_tr[0:63];
  logic       rv_tr[0:63];
  logic       err_tr[0:63];
  logic       rdy_tr[0:63];
  logic [7:0] rd_tr[0:63];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic record(input int c);
    ss_tr[c]   = ss_n;
    mosi_tr[c] = mosi;
    rv_tr[c]   = rsp_valid;
    err_tr[c]  = err;
    rdy_tr[c]  = cmd_ready;
    rd_tr[c]   = rsp_data;
  endtask

  // Called on a falling edge; presents one command for a single cycle.
  task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [7:0] mb,
                      input int n, input int rst_at);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (c == 1) cmd_valid = 1'b0;
      miso = (c >= 12 + RDW && c < 20 + RDW) ? mb[19 + RDW - c] : 1'b0;
      record(c);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_ss_n", ss_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_busy", busy, 0);
      end
      if (c == rst_at + 2) rst = 1'b0;
      @(negedge clk);
    end
    miso = 1'b0;
  endtask

  task automatic check_frame(input string nm, input vec_t v);
    int low;
    int nrv;
    int nerr;
    logic [10:0] got;
    low = 0; nrv = 0; nerr = 0; got = '0;
    for (int c = 0; c < NCYC; c++) begin
      if (ss_tr[c] == 1'b0) low++;
      if (rv_tr[c] == 1'b1) nrv++;
      if (err_tr[c] == 1'b1) nerr++;
    end
    chk({nm, "_ready"}, rdy_tr[0], 1);
    chk({nm, "_ss_low"}, low, v.ss_low);
    chk({nm, "_err_cnt"}, nerr, v.err);
    chk({nm, "_err_t1"}, err_tr[1], v.err);
    chk({nm, "_rsp_cnt"}, nrv, v.rsp);
    if (v.ss_low > 0) begin
      for (int k = 0; k <= 10; k++) got[10 - k] = mosi_tr[1 + k];
      chk({nm, "_mosi"}, got, v.mosi);
      chk({nm, "_ss_start"}, ss_tr[1], 0);
    end
    if (v.rsp) begin
      chk({nm, "_rsp_at"}, rv_tr[20 + RDW], 1);
      chk({nm, "_rsp_data"}, rd_tr[20 + RDW], v.mb);
    end
  endtask

  initial begin
    logic [1:0]  bop[3];
    logic [7:0]  bd[3];
    logic [10:0] bexp[3];
    int          bstart[3];
    vec_t        v;
    int          idx;
    bit          upd;
    int          nrv;
    logic [10:0] got;

    tbl[0] = '{op: 2'b11, d: 8'hFF, mb: 8'h00, mosi: 11'b0,              ss_low: 0,  err: 1'b1, rsp: 1'b0};
    tbl[1] = '{op: 2'b00, d: 8'hA5, mb: 8'h00, mosi: 11'b0_00_10100101, ss_low: 11, err: 1'b0, rsp: 1'b0};
    tbl[2] = '{op: 2'b01, d: 8'h5A, mb: 8'h00, mosi: 11'b0_01_01011010, ss_low: 11, err: 1'b0, rsp: 1'b0};
    tbl[3] = '{op: 2'b10, d: 8'h3C, mb: 8'h00, mosi: 11'b1_10_00111100, ss_low: 11, err: 1'b0, rsp: 1'b0};
    tbl[4] = '{op: 2'b11, d: 8'hFF, mb: 8'hC3, mosi: 11'b1_11_00000000, ss_low: 22, err: 1'b0, rsp: 1'b1};
    tbl[5] = '{op: 2'b11, d: 8'h00, mb: 8'h00, mosi: 11'b0,              ss_low: 0,  err: 1'b1, rsp: 1'b0};
    tbl[6] = '{op: 2'b10, d: 8'h81, mb: 8'h00, mosi: 11'b1_10_10000001, ss_low: 11, err: 1'b0, rsp: 1'b0};
    tbl[7] = '{op: 2'b10, d: 8'h7E, mb: 8'h00, mosi: 11'b1_10_01111110, ss_low: 11, err: 1'b0, rsp: 1'b0};
    tbl[8] = '{op: 2'b11, d: 8'hA5, mb: 8'h5A, mosi: 11'b1_11_00000000, ss_low: 22, err: 1'b0, rsp: 1'b1};

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("init_ss_n", ss_n, 1);
    chk("init_mosi", mosi, 0);
    chk("init_ready", cmd_ready, 1);
    chk("init_busy", busy, 0);
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_rsp_data", rsp_data, 8'h00);
    chk("init_err", err, 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].op, tbl[i].d, tbl[i].mb, NCYC, -1);
      check_frame($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset in the middle of a write frame.
    send(2'b00, 8'hFF, 8'h00, 12, 5);
    chk("midshift_ss_after", ss_tr[6], 1);
    chk("midshift_ready", cmd_ready, 1);
    chk("midshift_busy", busy, 0);

    // Back-to-back frames with cmd_valid held high.
    bop  = '{2'b00, 2'b01, 2'b10};
    bd   = '{8'hA5, 8'hC3, 8'h0F};
    bexp = '{11'b0_00_10100101, 11'b0_01_11000011, 11'b1_10_00001111};
    bstart = '{1, 14, 27};
    idx = 0; upd = 1'b0;
    cmd_op = bop[0]; cmd_data = bd[0]; cmd_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (upd) begin
        upd = 1'b0;
        idx++;
        if (idx < 3) begin
          cmd_op = bop[idx];
          cmd_data = bd[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      record(c);
      if (cmd_ready && cmd_valid) upd = 1'b1;
      @(negedge clk);
    end
    for (int f = 0; f < 3; f++) begin
      got = '0;
      for (int k = 0; k <= 10; k++) got[10 - k] = mosi_tr[bstart[f] + k];
      chk($sformatf("b2b_mosi%0d", f), got, bexp[f]);
      chk($sformatf("b2b_low_first%0d", f), ss_tr[bstart[f]], 0);
      chk($sformatf("b2b_low_last%0d", f), ss_tr[bstart[f] + 10], 0);
    end
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("b2b_gap_a%0d", f), ss_tr[bstart[f] + 11], 1);
      chk($sformatf("b2b_gap_b%0d", f), ss_tr[bstart[f] + 12], 1);
    end
    chk("b2b_idle_end", ss_tr[44], 1);

    // Reset during CAPTURE after four MISO samples.
    v = '{op: 2'b10, d: 8'h11, mb: 8'h00, mosi: 11'b1_10_00010001, ss_low: 11, err: 1'b0, rsp: 1'b0};
    send(v.op, v.d, v.mb, NCYC, -1);
    check_frame("cap_addr", v);
    send(2'b11, 8'h00, 8'hFF, NCYC, 19 );
    nrv = 0;
    for (int c = 0; c < NCYC; c++) if (rv_tr[c] == 1'b1) nrv++;
    chk("cap_rst_rsp_cnt", nrv, 0);
    chk("cap_rst_low_before", ss_tr[19], 0);
    v = '{op: 2'b11, d: 8'h00, mb: 8'h00, mosi: 11'b0, ss_low: 0, err: 1'b1, rsp: 1'b0};
    send(v.op, v.d, v.mb, NCYC, -1);
    check_frame("cap_after", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
